// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception arbiter slice.
// Holds ExcCode values, CP0 register numbers, the default exception vector,
// the arbiter state enum and the packed lane / winner payloads.
package cp0_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 5;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 3;

   // ExcCode values
   localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
   localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
   localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
   localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
   localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
   localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

   // CP0 register numbers
   localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
   localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
   localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
   localparam logic [REG_W-1:0] CP0_STATUS   = 5'd12;
   localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
   localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;

   localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MTC0_2 = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   // Exception-related view of one MEM-stage lane
   typedef struct packed {
      logic              valid;
      logic              exc_req;
      logic [CODE_W-1:0] exc_code;
      logic              eret;
      logic [XLEN-1:0]   pc;
      logic              bd;
      logic [XLEN-1:0]   badva;
   } lane_t;

   // Winner of the current cycle and the CP0 values it would commit
   typedef struct packed {
      logic              win_1;
      logic              win_2;
      logic              is_eret;
      logic [CODE_W-1:0] code;
      logic [XLEN-1:0]   epc_w;
      logic              bd;
      logic              badva_we;
      logic [XLEN-1:0]   badva;
   } sel_t;

   // AdEL / AdES are the only codes that load BadVAddr
   function automatic logic is_addr_exc(input logic [CODE_W-1:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_exc_arbiter_if.sv
// Bundle between the two MEM lanes / CP0 register file and the arbiter.
// slave  : arbiter side (lane/CP0 status in, flush/commit/write out)
// master : pipeline side (drives lane/CP0 status, receives arbiter results)
interface cp0_exc_arbiter_if;

   logic                         valid_1,     valid_2;
   logic                         exc_req_1,   exc_req_2;
   logic [cp0_pkg::CODE_W-1:0]   exc_code_1,  exc_code_2;
   logic                         eret_1,      eret_2;
   logic [cp0_pkg::XLEN-1:0]     pc_1,        pc_2;
   logic                         bd_1,        bd_2;
   logic [cp0_pkg::XLEN-1:0]     badva_1,     badva_2;
   logic                         int_pending;
   logic                         exl;
   logic [cp0_pkg::XLEN-1:0]     epc;
   logic                         mtc0_en_1,   mtc0_en_2;
   logic [cp0_pkg::REG_W-1:0]    mtc0_addr_1, mtc0_addr_2;
   logic [cp0_pkg::XLEN-1:0]     mtc0_data_1, mtc0_data_2;

   logic                         flush_1,     flush_2;
   logic                         stall;
   logic                         cp0_commit;
   logic [cp0_pkg::CODE_W-1:0]   cp0_exc_code;
   logic [cp0_pkg::XLEN-1:0]     cp0_epc_w;
   logic                         cp0_bd;
   logic                         cp0_badva_we;
   logic [cp0_pkg::XLEN-1:0]     cp0_badva;
   logic                         cp0_eret;
   logic                         cp0_w_en;
   logic [cp0_pkg::REG_W-1:0]    cp0_w_addr;
   logic [cp0_pkg::XLEN-1:0]     cp0_w_data;
   logic                         redirect_valid;
   logic [cp0_pkg::XLEN-1:0]     redirect_pc;

   modport slave (
      input  valid_1, valid_2, exc_req_1, exc_req_2, exc_code_1, exc_code_2,
             eret_1, eret_2, pc_1, pc_2, bd_1, bd_2, badva_1, badva_2,
             int_pending, exl, epc,
             mtc0_en_1, mtc0_en_2, mtc0_addr_1, mtc0_addr_2, mtc0_data_1, mtc0_data_2,
      output flush_1, flush_2, stall, cp0_commit, cp0_exc_code, cp0_epc_w, cp0_bd,
             cp0_badva_we, cp0_badva, cp0_eret, cp0_w_en, cp0_w_addr, cp0_w_data,
             redirect_valid, redirect_pc
   );

   modport master (
      output valid_1, valid_2, exc_req_1, exc_req_2, exc_code_1, exc_code_2,
             eret_1, eret_2, pc_1, pc_2, bd_1, bd_2, badva_1, badva_2,
             int_pending, exl, epc,
             mtc0_en_1, mtc0_en_2, mtc0_addr_1, mtc0_addr_2, mtc0_data_1, mtc0_data_2,
      input  flush_1, flush_2, stall, cp0_commit, cp0_exc_code, cp0_epc_w, cp0_bd,
             cp0_badva_we, cp0_badva, cp0_eret, cp0_w_en, cp0_w_addr, cp0_w_data,
             redirect_valid, redirect_pc
   );

endinterface

// File: rtl/cp0_exc_select.sv
// Combinational age-ordered winner selection between the two MEM lanes.
// Priority: lane 1 exception/ERET, interrupt (on lane 1), lane 2 exception/ERET.
// Interrupts participate only when CP0_ARB_INT_EN is defined.
// Ports: lane_1/lane_2 lane payloads, int_pending/exl CP0 status, sel winner.
module cp0_exc_select
   import cp0_pkg::*;
(
   input  lane_t lane_1,
   input  lane_t lane_2,
   input  logic  int_pending,
   input  logic  exl,
   output sel_t  sel
);

   logic  lane1_hit;
   logic  lane2_hit;
   logic  int_hit;
   lane_t src;

   assign lane1_hit = lane_1.valid & (lane_1.exc_req | lane_1.eret);
   assign lane2_hit = lane_2.valid & (lane_2.exc_req | lane_2.eret);

`ifdef CP0_ARB_INT_EN
   assign int_hit = int_pending & ~exl & lane_1.valid;
`else
   logic unused_int;
   assign unused_int = int_pending | exl;
   assign int_hit    = 1'b0;
`endif

   // An instruction flagged both as exception and ERET commits the exception
   always_comb begin
      sel = '0;
      src = lane_1;
      if (lane1_hit) begin
         sel.win_1   = 1'b1;
         sel.is_eret = ~lane_1.exc_req;
         sel.code    = lane_1.exc_code;
      end else if (int_hit) begin
         sel.win_1   = 1'b1;
         sel.code    = EXC_INT;
      end else if (lane2_hit) begin
         sel.win_2   = 1'b1;
         sel.is_eret = ~lane_2.exc_req;
         sel.code    = lane_2.exc_code;
         src         = lane_2;
      end
      sel.epc_w    = src.bd ? (src.pc - XLEN'(4)) : src.pc;
      sel.bd       = src.bd;
      // badva equals pc for fetch AdEL, so the lane badva is always the value to write
      sel.badva    = src.badva;
      sel.badva_we = (sel.win_1 | sel.win_2) & ~sel.is_eret & is_addr_exc(sel.code);
   end

endmodule

// File: rtl/cp0_exc_arbiter.sv
// Exception/interrupt/ERET commit arbiter and MTC0 write sequencer.
// Ports: clk, reset (sync, active-high), bus (cp0_exc_arbiter_if.slave).
// Parameters: EXC_VECTOR exception entry PC, FLUSH_CYCLES drain length (1..7).
// Config macro: CP0_ARB_INT_EN enables interrupt commits (see cp0_exc_select).
// flush_*, stall and cp0_w_* are combinational; commit/redirect outputs are registered.
module cp0_exc_arbiter
   import cp0_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   cp0_exc_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_MTC0_2 = ST_MTC0_2;
   localparam logic [1:0] S_DRAIN  = ST_DRAIN;

   lane_t lane_1, lane_2;
   sel_t  sel;

   logic [1:0]        state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [REG_W-1:0]  buf_addr_q, buf_addr_d;
   logic [XLEN-1:0]   buf_data_q, buf_data_d;
   logic              commit_q,   commit_d;
   logic              eret_q,     eret_d;
   logic              rv_q,       rv_d;
   logic [XLEN-1:0]   rpc_q,      rpc_d;
   logic [CODE_W-1:0] code_q,     code_d;
   logic [XLEN-1:0]   epc_q,      epc_d;
   logic              bd_q,       bd_d;
   logic              bwe_q,      bwe_d;
   logic [XLEN-1:0]   badva_q,    badva_d;

   logic              flush_1, flush_2, stall;
   logic              w_en;
   logic [REG_W-1:0]  w_addr;
   logic [XLEN-1:0]   w_data;
   logic              mtc_1, mtc_2;

   always_comb begin
      lane_1 = '{valid: bus.valid_1, exc_req: bus.exc_req_1, exc_code: bus.exc_code_1,
                 eret: bus.eret_1, pc: bus.pc_1, bd: bus.bd_1, badva: bus.badva_1};
      lane_2 = '{valid: bus.valid_2, exc_req: bus.exc_req_2, exc_code: bus.exc_code_2,
                 eret: bus.eret_2, pc: bus.pc_2, bd: bus.bd_2, badva: bus.badva_2};
   end

   cp0_exc_select u_select (
      .lane_1      (lane_1),
      .lane_2      (lane_2),
      .int_pending (bus.int_pending),
      .exl         (bus.exl),
      .sel         (sel)
   );

   // Next state, commit capture and MTC0 sequencing
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      commit_d   = 1'b0;
      eret_d     = 1'b0;
      rv_d       = 1'b0;
      bwe_d      = 1'b0;
      rpc_d      = rpc_q;
      code_d     = code_q;
      epc_d      = epc_q;
      bd_d       = bd_q;
      badva_d    = badva_q;
      flush_1    = 1'b0;
      flush_2    = 1'b0;
      stall      = 1'b0;
      w_en       = 1'b0;
      w_addr     = '0;
      w_data     = '0;
      mtc_1      = 1'b0;
      mtc_2      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Lane 1 MTC0 dies with its own exception/interrupt; lane 2 MTC0 dies with any winner
            mtc_1 = bus.mtc0_en_1 & ~(sel.win_1 & ~sel.is_eret);
            mtc_2 = bus.mtc0_en_2 & ~sel.win_1 & ~sel.win_2;

            if (sel.win_1 | sel.win_2) begin
               flush_1 = sel.win_1;
               flush_2 = 1'b1;
               rv_d    = 1'b1;
               state_d = S_DRAIN;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               if (sel.is_eret) begin
                  eret_d = 1'b1;
                  rpc_d  = bus.epc;
               end else begin
                  commit_d = 1'b1;
                  rpc_d    = EXC_VECTOR;
                  code_d   = sel.code;
                  epc_d    = sel.epc_w;
                  bd_d     = sel.bd;
                  bwe_d    = sel.badva_we;
                  if (sel.badva_we) begin
                     badva_d = sel.badva;
                  end
               end
            end

            // Same-address pair collapses to the younger write
            if (mtc_1 && mtc_2 && (bus.mtc0_addr_1 != bus.mtc0_addr_2)) begin
               w_en       = 1'b1;
               w_addr     = bus.mtc0_addr_1;
               w_data     = bus.mtc0_data_1;
               stall      = 1'b1;
               buf_addr_d = bus.mtc0_addr_2;
               buf_data_d = bus.mtc0_data_2;
               state_d    = S_MTC0_2;
            end else if (mtc_2) begin
               w_en   = 1'b1;
               w_addr = bus.mtc0_addr_2;
               w_data = bus.mtc0_data_2;
            end else if (mtc_1) begin
               w_en   = 1'b1;
               w_addr = bus.mtc0_addr_1;
               w_data = bus.mtc0_data_1;
            end
         end

         S_MTC0_2: begin
            w_en    = 1'b1;
            w_addr  = buf_addr_q;
            w_data  = buf_data_q;
            state_d = S_IDLE;
         end

         S_DRAIN: begin
            flush_1 = 1'b1;
            flush_2 = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         commit_q   <= 1'b0;
         eret_q     <= 1'b0;
         rv_q       <= 1'b0;
         rpc_q      <= EXC_VECTOR;
         code_q     <= '0;
         epc_q      <= '0;
         bd_q       <= 1'b0;
         bwe_q      <= 1'b0;
         badva_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         commit_q   <= commit_d;
         eret_q     <= eret_d;
         rv_q       <= rv_d;
         rpc_q      <= rpc_d;
         code_q     <= code_d;
         epc_q      <= epc_d;
         bd_q       <= bd_d;
         bwe_q      <= bwe_d;
         badva_q    <= badva_d;
      end
   end

   assign bus.flush_1        = flush_1;
   assign bus.flush_2        = flush_2;
   assign bus.stall          = stall;
   assign bus.cp0_w_en       = w_en;
   assign bus.cp0_w_addr     = w_addr;
   assign bus.cp0_w_data     = w_data;
   assign bus.cp0_commit     = commit_q;
   assign bus.cp0_eret       = eret_q;
   assign bus.redirect_valid = rv_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.cp0_exc_code   = code_q;
   assign bus.cp0_epc_w      = epc_q;
   assign bus.cp0_bd         = bd_q;
   assign bus.cp0_badva_we   = bwe_q;
   assign bus.cp0_badva      = badva_q;

endmodule

// File: tb/tb_cp0_exc_arbiter.sv
// Self-checking bench for cp0_exc_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_cp0_exc_arbiter;

   localparam logic [31:0] VEC   = 32'hBFC0_0380;
   localparam int unsigned FLUSH = 2;
`ifdef CP0_ARB_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   cp0_exc_arbiter_if bus();

   cp0_exc_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FLUSH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: pending drain cycles, one queued CP0 write, expected registered outputs
   bit          armed = 1'b0;
   int          drain_left = 0;
   bit          pend_v = 1'b0;
   logic [4:0]  pend_a = '0;
   logic [31:0] pend_d = '0;
   logic        e_commit = 1'b0, e_eret = 1'b0, e_rv = 1'b0, e_bwe = 1'b0, e_bd = 1'b0;
   logic [31:0] e_rpc = VEC, e_epc = '0, e_badva = '0;
   logic [4:0]  e_code = '0;

   logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.valid_1 = 0; bus.exc_req_1 = 0; bus.exc_code_1 = '0; bus.eret_1 = 0;
      bus.pc_1 = '0; bus.bd_1 = 0; bus.badva_1 = '0;
      bus.valid_2 = 0; bus.exc_req_2 = 0; bus.exc_code_2 = '0; bus.eret_2 = 0;
      bus.pc_2 = '0; bus.bd_2 = 0; bus.badva_2 = '0;
      bus.int_pending = 0; bus.exl = 0; bus.epc = '0;
      bus.mtc0_en_1 = 0; bus.mtc0_addr_1 = '0; bus.mtc0_data_1 = '0;
      bus.mtc0_en_2 = 0; bus.mtc0_addr_2 = '0; bus.mtc0_data_2 = '0;
   endtask

   task automatic rnd();
      bus.valid_1     = ($urandom_range(0, 3) != 0);
      bus.exc_req_1   = ($urandom_range(0, 5) == 0);
      bus.exc_code_1  = codes[$urandom_range(0, 6)];
      bus.eret_1      = ($urandom_range(0, 9) == 0);
      bus.pc_1        = 32'($urandom) & 32'hFFFF_FFFC;
      bus.bd_1        = 1'($urandom_range(0, 1));
      bus.badva_1     = ($urandom_range(0, 1) != 0) ? bus.pc_1 : 32'($urandom);
      bus.valid_2     = ($urandom_range(0, 3) != 0);
      bus.exc_req_2   = ($urandom_range(0, 5) == 0);
      bus.exc_code_2  = codes[$urandom_range(0, 6)];
      bus.eret_2      = ($urandom_range(0, 9) == 0);
      bus.pc_2        = 32'($urandom) & 32'hFFFF_FFFC;
      bus.bd_2        = 1'($urandom_range(0, 1));
      bus.badva_2     = ($urandom_range(0, 1) != 0) ? bus.pc_2 : 32'($urandom);
      bus.int_pending = ($urandom_range(0, 7) == 0);
      bus.exl         = 1'($urandom_range(0, 1));
      bus.epc         = 32'($urandom);
      bus.mtc0_en_1   = ($urandom_range(0, 2) == 0);
      bus.mtc0_addr_1 = 5'($urandom_range(8, 14));
      bus.mtc0_data_1 = 32'($urandom);
      bus.mtc0_en_2   = ($urandom_range(0, 2) == 0);
      bus.mtc0_addr_2 = 5'($urandom_range(8, 14));
      bus.mtc0_data_2 = 32'($urandom);
      reset           = ($urandom_range(0, 39) == 0);
   endtask

   // Mid-cycle: check registered outputs, then predict this cycle's combinational outputs and next registers
   task automatic half();
      int          win;
      bit          ier, a1, a2;
      logic [4:0]  wcode;
      logic [31:0] wpc, wbva;
      logic        wbd;
      logic        xf1, xf2, xst, xwen;
      logic [4:0]  xwa;
      logic [31:0] xwd;
      #3;
      if (armed) begin
         chk1("cp0_commit", bus.cp0_commit, e_commit);
         chk1("cp0_eret", bus.cp0_eret, e_eret);
         chk1("redirect_valid", bus.redirect_valid, e_rv);
         chk32("redirect_pc", bus.redirect_pc, e_rpc);
         chk1("cp0_badva_we", bus.cp0_badva_we, e_bwe);
         if (e_commit) begin
            chk32("cp0_exc_code", 32'(bus.cp0_exc_code), 32'(e_code));
            chk32("cp0_epc_w", bus.cp0_epc_w, e_epc);
            chk1("cp0_bd", bus.cp0_bd, e_bd);
         end
         if (e_bwe) chk32("cp0_badva", bus.cp0_badva, e_badva);
      end
      xf1 = 0; xf2 = 0; xst = 0; xwen = 0; xwa = '0; xwd = '0;
      e_commit = 0; e_eret = 0; e_rv = 0; e_bwe = 0;
      if (reset) begin
         armed = 1'b1; drain_left = 0; pend_v = 0; e_rpc = VEC;
      end else begin
         if (drain_left > 0) begin
            xf1 = 1; xf2 = 1; drain_left--;
         end else if (pend_v) begin
            xwen = 1; xwa = pend_a; xwd = pend_d; pend_v = 0;
         end else begin
            win = 0; ier = 0; wcode = '0; wpc = '0; wbva = '0; wbd = 0;
            if (bus.valid_1 && (bus.exc_req_1 || bus.eret_1)) begin
               win = 1; ier = !bus.exc_req_1; wcode = bus.exc_code_1;
               wpc = bus.pc_1; wbd = bus.bd_1; wbva = bus.badva_1;
            end else if (INT_EN && bus.int_pending && !bus.exl && bus.valid_1) begin
               win = 1; wcode = 5'd0; wpc = bus.pc_1; wbd = bus.bd_1;
            end else if (bus.valid_2 && (bus.exc_req_2 || bus.eret_2)) begin
               win = 2; ier = !bus.exc_req_2; wcode = bus.exc_code_2;
               wpc = bus.pc_2; wbd = bus.bd_2; wbva = bus.badva_2;
            end
            if (win != 0) begin
               xf1 = (win == 1); xf2 = 1; drain_left = int'(FLUSH); e_rv = 1;
               if (ier) begin
                  e_eret = 1; e_rpc = bus.epc;
               end else begin
                  e_commit = 1; e_rpc = VEC; e_code = wcode; e_bd = wbd;
                  e_epc = wbd ? wpc - 32'd4 : wpc;
                  e_bwe = (wcode == 5'd4) || (wcode == 5'd5);
                  e_badva = wbva;
               end
            end
            a1 = bus.mtc0_en_1 && !(win == 1 && !ier);
            a2 = bus.mtc0_en_2 && (win == 0);
            if (a1 && a2 && bus.mtc0_addr_1 == bus.mtc0_addr_2) begin
               xwen = 1; xwa = bus.mtc0_addr_2; xwd = bus.mtc0_data_2;
            end else if (a1 && a2) begin
               xwen = 1; xwa = bus.mtc0_addr_1; xwd = bus.mtc0_data_1; xst = 1;
               pend_v = 1; pend_a = bus.mtc0_addr_2; pend_d = bus.mtc0_data_2;
            end else if (a1) begin
               xwen = 1; xwa = bus.mtc0_addr_1; xwd = bus.mtc0_data_1;
            end else if (a2) begin
               xwen = 1; xwa = bus.mtc0_addr_2; xwd = bus.mtc0_data_2;
            end
         end
         chk1("flush_1", bus.flush_1, xf1);
         chk1("flush_2", bus.flush_2, xf2);
         chk1("stall", bus.stall, xst);
         chk1("cp0_w_en", bus.cp0_w_en, xwen);
         if (xwen) begin
            chk32("cp0_w_addr", 32'(bus.cp0_w_addr), 32'(xwa));
            chk32("cp0_w_data", bus.cp0_w_data, xwd);
         end
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      half();
      edge_();
   endtask

   initial begin
      clr();
      reset = 1;
      edge_();
      tick();
      tick();
      reset = 0;

      // Reset values
      half();
      chk1("rst_commit", bus.cp0_commit, 1'b0);
      chk32("rst_redirect_pc", bus.redirect_pc, VEC);
      edge_();

      // Lane 1 exception beats lane 2
      bus.valid_1 = 1; bus.exc_req_1 = 1; bus.exc_code_1 = 5'd12; bus.pc_1 = 32'h8000_0100;
      bus.valid_2 = 1; bus.exc_req_2 = 1; bus.exc_code_2 = 5'd8; bus.pc_2 = 32'h8000_0104;
      half();
      chk1("tp1_flush_1", bus.flush_1, 1'b1);
      chk1("tp1_flush_2", bus.flush_2, 1'b1);
      edge_();
      clr();
      chk1("tp1_commit", bus.cp0_commit, 1'b1);
      chk32("tp1_code", 32'(bus.cp0_exc_code), 32'd12);
      chk32("tp1_epc", bus.cp0_epc_w, 32'h8000_0100);
      chk32("tp1_redirect", bus.redirect_pc, VEC);
      tick(); tick();

      // Lane 2 delay-slot exception, lane 1 MTC0 completes
      bus.valid_1 = 1; bus.mtc0_en_1 = 1; bus.mtc0_addr_1 = 5'd12; bus.mtc0_data_1 = 32'h0000_00A5;
      bus.valid_2 = 1; bus.exc_req_2 = 1; bus.exc_code_2 = 5'd8; bus.bd_2 = 1; bus.pc_2 = 32'h8000_0204;
      half();
      chk1("tp2_w_en", bus.cp0_w_en, 1'b1);
      chk32("tp2_w_addr", 32'(bus.cp0_w_addr), 32'd12);
      chk1("tp2_flush_1", bus.flush_1, 1'b0);
      chk1("tp2_flush_2", bus.flush_2, 1'b1);
      edge_();
      clr();
      chk32("tp2_epc", bus.cp0_epc_w, 32'h8000_0200);
      chk1("tp2_bd", bus.cp0_bd, 1'b1);
      tick(); tick();

      // Two MTC0s to different registers serialize with one stall cycle
      bus.valid_1 = 1; bus.mtc0_en_1 = 1; bus.mtc0_addr_1 = 5'd11; bus.mtc0_data_1 = 32'd5;
      bus.valid_2 = 1; bus.mtc0_en_2 = 1; bus.mtc0_addr_2 = 5'd14; bus.mtc0_data_2 = 32'h1234;
      half();
      chk1("tp3_stall", bus.stall, 1'b1);
      chk32("tp3_w_addr_n", 32'(bus.cp0_w_addr), 32'd11);
      chk32("tp3_w_data_n", bus.cp0_w_data, 32'd5);
      edge_();
      half();
      chk1("tp3_stall_n1", bus.stall, 1'b0);
      chk32("tp3_w_addr_n1", 32'(bus.cp0_w_addr), 32'd14);
      chk32("tp3_w_data_n1", bus.cp0_w_data, 32'h1234);
      edge_();
      clr();
      tick();

      // Two MTC0s to the same register: younger write only, no stall
      bus.valid_1 = 1; bus.mtc0_en_1 = 1; bus.mtc0_addr_1 = 5'd9; bus.mtc0_data_1 = 32'd1;
      bus.valid_2 = 1; bus.mtc0_en_2 = 1; bus.mtc0_addr_2 = 5'd9; bus.mtc0_data_2 = 32'd2;
      half();
      chk32("same_addr_data", bus.cp0_w_data, 32'd2);
      chk1("same_addr_stall", bus.stall, 1'b0);
      edge_();
      clr();
      tick();

      // Interrupt waits for a valid lane 1
      bus.int_pending = 1;
      repeat (3) tick();
      bus.valid_1 = 1; bus.pc_1 = 32'h8000_0300;
      tick();
      clr();
      chk1("tp4_commit", bus.cp0_commit, INT_EN);
      tick(); tick();

      // Lane 2 ERET, then drain window
      bus.valid_2 = 1; bus.eret_2 = 1; bus.epc = 32'h8000_0400;
      tick();
      clr();
      chk1("tp5_eret", bus.cp0_eret, 1'b1);
      chk1("tp5_commit", bus.cp0_commit, 1'b0);
      chk32("tp5_redirect", bus.redirect_pc, 32'h8000_0400);
      tick();
      bus.valid_1 = 1; bus.exc_req_1 = 1; bus.exc_code_1 = 5'd9; bus.pc_1 = 32'h8000_0500;
      half();
      chk1("tp5_drain_flush", bus.flush_1, 1'b1);
      edge_();
      chk1("tp5_n2_ignored", bus.cp0_commit, 1'b0);
      tick();
      clr();
      chk1("tp5_n3_accepted", bus.cp0_commit, 1'b1);
      chk32("tp5_n3_code", 32'(bus.cp0_exc_code), 32'd9);
      tick(); tick();

      // Reset in the middle of DRAIN
      bus.valid_1 = 1; bus.exc_req_1 = 1; bus.exc_code_1 = 5'd4; bus.pc_1 = 32'h8000_0600;
      bus.badva_1 = 32'h8000_0600;
      tick();
      clr();
      reset = 1;
      tick();
      reset = 0;
      half();
      chk1("tp6_commit", bus.cp0_commit, 1'b0);
      chk1("tp6_redirect_valid", bus.redirect_valid, 1'b0);
      chk32("tp6_redirect_pc", bus.redirect_pc, VEC);
      chk32("tp6_code", 32'(bus.cp0_exc_code), 32'd0);
      chk32("tp6_epc", bus.cp0_epc_w, 32'd0);
      chk1("tp6_badva_we", bus.cp0_badva_we, 1'b0);
      chk32("tp6_badva", bus.cp0_badva, 32'd0);
      chk1("tp6_flush_1", bus.flush_1, 1'b0);
      chk1("tp6_flush_2", bus.flush_2, 1'b0);
      edge_();

      // Reset in the middle of MTC0_2 discards the buffered write
      bus.mtc0_en_1 = 1; bus.mtc0_addr_1 = 5'd11; bus.mtc0_data_1 = 32'd7;
      bus.mtc0_en_2 = 1; bus.mtc0_addr_2 = 5'd14; bus.mtc0_data_2 = 32'd8;
      tick();
      clr();
      reset = 1;
      tick();
      reset = 0;
      half();
      chk1("rst_mtc0_discard", bus.cp0_w_en, 1'b0);
      edge_();

      // Random traffic against the model
      repeat (800) begin
         rnd();
         tick();
      end
      reset = 0;
      clr();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_exc_arbiter.md
# cp0_exc_arbiter

Exception/interrupt arbiter and CP0 write sequencer for the dual-issue MIPS pipeline. Sits between the two MEM-stage lanes and the CP0 register file. Each cycle it picks at most one exception, interrupt or ERET to commit, based on age order (lane 1 older than lane 2). It then flushes the pipeline, redirects fetch, and serializes simultaneous MTC0 writes into CP0's single write port.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC
- FLUSH_CYCLES, 2, post-commit drain cycles (1..7)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid_1 / valid_2  in  1  lane holds a committing instruction in MEM
- exc_req_1 / exc_req_2  in  1  lane instruction raised an exception
- exc_code_1 / exc_code_2  in  5  ExcCode
- eret_1 / eret_2  in  1  lane instruction is ERET
- pc_1 / pc_2  in  32  lane instruction PC
- bd_1 / bd_2  in  1  lane instruction is in a delay slot
- badva_1 / badva_2  in  32  faulting address for AdEL/AdES
- int_pending  in  1  CP0 masked interrupt pending (IP&IM, IE)
- exl  in  1  CP0 Status.EXL
- epc  in  32  CP0 EPC
- mtc0_en_1 / mtc0_en_2  in  1  MTC0 request
- mtc0_addr_1 / mtc0_addr_2  in  5  MTC0 target
- mtc0_data_1 / mtc0_data_2  in  32  MTC0 data
- flush_1 / flush_2  out  1  kill lane result (combinational)
- stall  out  1  freeze IF..MEM one cycle
- cp0_commit  out  1  one-cycle exception commit pulse
- cp0_exc_code  out  5  committed ExcCode
- cp0_epc_w  out  32  EPC to write
- cp0_bd  out  1  Cause.BD to write
- cp0_badva_we  out  1  write BadVAddr
- cp0_badva  out  32  BadVAddr value
- cp0_eret  out  1  one-cycle ERET pulse (clear EXL)
- cp0_w_en  out  1  MTC0 write strobe
- cp0_w_addr  out  5  MTC0 target
- cp0_w_data  out  32  MTC0 data
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, MTC0_2, DRAIN.
- Winner selection in IDLE, combinational, in this priority order:
  1. lane 1 exception or ERET (requires valid_1)
  2. interrupt (int_pending & !exl & valid_1), attributed to lane 1
  3. lane 2 exception or ERET (requires valid_2)
- Lane 1 win: flush_1 and flush_2 asserted. Lane 1's MTC0 is suppressed for exceptions and interrupts. Lane 2's MTC0 is always suppressed.
- Lane 2 win: flush_2 only. Lane 1 completes normally, including its MTC0.
- Exception commit: cp0_epc_w = bd ? pc-4 : pc. cp0_bd = bd. Interrupt uses ExcCode 0.
- BadVAddr: cp0_badva_we is set for code 4/5. cp0_badva = badva, except for instruction-fetch AdEL (badva == pc), where it equals pc.
- Redirect target: EXC_VECTOR for exceptions and interrupts, epc input for ERET.
- ERET with exl=0 still commits as ERET; CP0 treats the clear as a no-op.
- MTC0, no winner:
  - single request: written the same cycle.
  - both requests, different addresses: lane 1 written, lane 2 buffered, stall=1, go to MTC0_2. Lane 2 is written the next cycle, then back to IDLE.
  - both requests, same address: lane 2 only, no stall.
- After a commit, the FSM enters DRAIN for FLUSH_CYCLES cycles. In DRAIN, flush_1 and flush_2 are held high and all requests are ignored.
- Interrupt pending with no valid lane: wait, do not commit.

## Timing
- Cycle N: winner detected, flush_* combinational.
- Cycle N+1: cp0_commit/cp0_eret, redirect_valid, redirect_pc registered, one-cycle pulses; DRAIN begins.
- Cycle N+1+FLUSH_CYCLES: back in IDLE, requests accepted again.
- Reset values: all outputs 0 and state IDLE, except redirect_pc = EXC_VECTOR.
- Reset mid-DRAIN or mid-MTC0_2: return to IDLE and discard the buffered write.
- Requests arriving during MTC0_2: ignored. Stall guarantees the pipeline holds them.

## Configuration
- CP0_ARB_INT_EN:
  - defined: int_pending participates at priority 2.
  - undefined: int_pending is ignored, the port is kept, and only exceptions and ERET commit.

## Structure
- Package cp0_pkg holds:
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12
  - CP0 register addresses: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14
  - default EXC_VECTOR
  - state enum
- Sub-module cp0_exc_select: purely combinational winner/priority logic. The top level keeps the FSM and output registers.

## Test plan
- exc_req_1=1, code=12, pc_1=0x8000_0100, bd_1=0, exc_req_2=1 -> flush_1=flush_2=1 at N. At N+1: cp0_commit=1, code=12, epc_w=0x8000_0100, redirect_pc=0xBFC0_0380. Lane 2 ignored.
- Lane 1 normal with mtc0 to addr 12; lane 2 exc code 8, bd_2=1, pc_2=0x8000_0204 -> cp0_w_en for Status at N, flush_2 only. At N+1: epc_w=0x8000_0200, cp0_bd=1.
- MTC0 lane 1 addr 11 data 5, lane 2 addr 14 data 0x1234 -> stall=1 at N with Compare written. At N+1: EPC=0x1234 written, stall=0.
- int_pending=1, exl=0, valid_1=0 for 3 cycles, then valid_1=1 pc_1=0x8000_0300 -> no commit until valid. Then code 0, epc_w=0x8000_0300; with macro undefined, never commits.
- eret_2=1, epc=0x8000_0400, FLUSH_CYCLES=2 -> cp0_eret pulse and redirect_pc=0x8000_0400 at N+1. New exc_req_1 at N+2 ignored; one at N+3 is accepted.
- reset asserted during DRAIN -> next cycle all outputs 0, redirect_pc=0xBFC0_0380, state IDLE.
